uart_tx_arbiter: RTL and testbench

Shares one UART transmitter byte interface (tx_data/tx_valid/tx_ready) among NUM_REQ requesters.
- Round-robin arbitration with packet lock: a granted requester holds the transmitter until its last byte, or until MAX_BURST bytes have been sent.
- Sits between on-chip byte producers (console, debug, status) and the UART controller's transmit port.

---
 rtl/uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter byte port among NUM_REQ byte producers.
// Round-robin arbitration with packet lock: once granted, a requester keeps
// the transmitter until it sends a byte flagged req_last, or until MAX_BURST
// bytes have been sent in this grant. Then the arbiter returns to IDLE for one
// cycle and re-arbitrates, starting the search just after the previous holder.
//
// Handshake: a byte moves on any cycle where tx_valid && tx_ready are both
// high. tx_valid never waits on tx_ready. req_ready[i] is high only for the
// granted requester, only in SEND, and only when tx_ready is high, so a
// requester sees its byte consumed exactly when (req_valid[i] && req_ready[i]).
// No byte moves during a cycle with rst high.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   MAX_BURST    bytes per grant before forced re-arbitration (1..256)
//   IDLE_TIMEOUT stall cycles before a silent holder loses its grant
//                (only used when UART_ARB_TIMEOUT_EN is defined)
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   Defined   : a holder that keeps req_valid low for IDLE_TIMEOUT consecutive
//               cycles loses the grant and the sticky timeout_err flag sets.
//   Undefined : the grant is held indefinitely; timeout_err is tied to 0.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_data     NUM_REQ bytes, requester i on bits [8i+7:8i]
//   req_valid    requester i has a byte
//   req_last     requester i's byte ends its packet
//   req_ready    requester i's byte is accepted this cycle
//   tx_data      byte to the UART transmitter
//   tx_valid     tx_data is valid
//   tx_ready     UART transmitter accepts the byte
//   grant_id     current (or most recent) grant holder
//   busy         FSM is in SEND (the FSM state made visible)
//   timeout_err  sticky: a grant was revoked by the stall timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  // Elaboration-time range check of the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 256 ||
      IDLE_TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;

  // ---------------------------------------------------------------------------
  // Unpack the flat data bus so the holder's byte is a plain array lookup.
  // ---------------------------------------------------------------------------
  logic [7:0] data_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*8 +: 8];
    end
  end

  // Signals of the current grant holder.
  logic [7:0] hold_data;
  logic       hold_valid;
  logic       hold_last;

  assign hold_data  = data_arr[grant_id];
  assign hold_valid = req_valid[grant_id];
  assign hold_last  = req_last[grant_id];

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester scanning rr_ptr+1, rr_ptr+2, ...
  // modulo NUM_REQ. rr_ptr itself is scanned last, so the previous holder
  // only wins again when nobody else is asking.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] pick;
  logic          pick_found;

  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!pick_found && req_valid[IW'((int'(rr_ptr) + off) % NUM_REQ)]) begin
        pick       = IW'((int'(rr_ptr) + off) % NUM_REQ);
        pick_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit side. Outputs are gated by rst so nothing transfers in the
  // reset cycle even if the FSM was mid-packet.
  // ---------------------------------------------------------------------------
  logic in_send;
  logic xfer;
  logic last_beat;

  assign in_send   = (state == SEND) && !rst;
  assign tx_valid  = in_send && hold_valid;
  assign tx_data   = (state == SEND) ? hold_data : 8'h00;
  assign xfer      = tx_valid && tx_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign busy      = (state == SEND);

  always_comb begin
    req_ready = '0;
    if (in_send && tx_ready) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall timeout (optional). stall_expire is high on the cycle that would be
  // the IDLE_TIMEOUT-th consecutive cycle with the holder's req_valid low.
  // Because it needs req_valid low it can never coincide with a transfer.
  // ---------------------------------------------------------------------------
  logic stall_expire;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [SW-1:0] STALL_LIMIT = SW'(IDLE_TIMEOUT - 1);

  logic [SW-1:0] stall_cnt;
  logic          timeout_flag;

  assign stall_expire = (state == SEND) && !hold_valid && (stall_cnt == STALL_LIMIT);
  assign timeout_err  = timeout_flag;
`else
  assign stall_expire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM and all registered state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt    <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
          stall_cnt <= '0;
`endif
          // grant_id keeps the last holder until a new pick is made.
          if (pick_found) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= SEND;
          end
        end

        SEND: begin
`ifdef UART_ARB_TIMEOUT_EN
          // Only cycles with the holder silent count; tx_ready back-pressure
          // with a valid byte pending clears the counter.
          if (hold_valid) begin
            stall_cnt <= '0;
          end else if (!stall_expire) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
          if (stall_expire) begin
            timeout_flag <= 1'b1;
          end
`endif
          if (stall_expire) begin
            state    <= IDLE;
            rr_ptr   <= grant_id;
            beat_cnt <= '0;
          end else if (xfer) begin
            if (hold_last || last_beat) begin
              state    <= IDLE;
              rr_ptr   <= grant_id;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter with NUM_REQ=4, MAX_BURST=16, IDLE_TIMEOUT=8.
// Inputs are driven just after the falling edge and outputs are sampled 1ns
// later. A cycle-level reference model (holder index, bytes sent in the
// current grant, last holder) predicts every output each cycle. On top of it:
// a table of fixed vectors, hand-written sequences for the multi-cycle
// corners, and a randomized run. Sequences that move packets keep an
// expected queue of {grant, byte} transfers.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int IT = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic [N*8-1:0] req_data;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  bit          mon_on   = 1'b0;
  bit          model_on = 1'b0;
  logic [N-1:0] acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who holds the transmitter and how many bytes it has sent.
  // m_owner = -1 means no grant.
  // ---------------------------------------------------------------------------
  int m_owner;
  int m_last_owner;
  int m_shown;
  int m_sent;
  int m_stall;
  bit m_terr;

  task automatic model_update();
    if (rst) begin
      m_owner      = -1;
      m_last_owner = N - 1;
      m_shown      = 0;
      m_sent       = 0;
      m_stall      = 0;
      m_terr       = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last_owner + k) % N;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c;
          m_shown = c;
          m_sent  = 0;
          m_stall = 0;
        end
      end
    end else if (req_valid[m_owner]) begin
      m_stall = 0;
      if (tx_ready) begin
        m_sent++;
        if (req_last[m_owner] || m_sent == MB) begin
          m_last_owner = m_owner;
          m_owner      = -1;
        end
      end
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      m_stall++;
      if (m_stall == IT) begin
        m_terr       = 1'b1;
        m_last_owner = m_owner;
        m_owner      = -1;
      end
`endif
    end
  endtask

  // One clock cycle: check outputs against the model, run the transfer
  // monitor, advance the model, then return just after the falling edge.
  task automatic cycle();
    logic [N-1:0] e_rdy;
    logic         e_tv;
    logic [7:0]   e_data;
    #1;
    if (model_on) begin
      e_rdy  = '0;
      e_tv   = 1'b0;
      e_data = 8'h00;
      if (m_owner >= 0 && !rst) begin
        e_tv   = req_valid[m_owner];
        e_data = req_data[m_owner*8 +: 8];
        if (tx_ready) e_rdy[m_owner] = 1'b1;
      end
      chk("tx_valid", tx_valid, e_tv);
      chk("req_ready", req_ready, e_rdy);
      chk("busy", busy, m_owner >= 0);
      chk("grant_id", grant_id, m_shown);
      chk("timeout_err", timeout_err, m_terr);
      if (e_tv) chk("tx_data", tx_data, e_data);
    end
    acc = req_ready & req_valid;
    if (mon_on && tx_valid === 1'b1 && tx_ready) begin
      if (exp_q.size() == 0) chk("xfer_extra", {grant_id, tx_data}, 32'hFFFF);
      else                   chk("xfer_seq", {6'b0, grant_id, tx_data}, exp_q.pop_front());
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Table vectors: all four requesters valid with 1-byte packets.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         tr;
    logic         etv;
    logic         ebusy;
    logic [1:0]   eg;
    logic [N-1:0] erdy;
    logic [7:0]   edata;
  } vec_t;

  vec_t tbl [13];

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k2;
    bit done3;
    int k;
    int pat [6];

    rst = 1'b1;
    idle_inputs();
    model_on = 1'b0;
    cycle();
    rst = 1'b0;
    model_on = 1'b1;

    // --- Reset state ---------------------------------------------------------
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_terr", timeout_err, 0);
    cycle();

    // --- Table-driven round robin -------------------------------------------
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'h10};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 8'h00};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 8'h12};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 8'h00};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 8'h13};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 8'h00};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'h10};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00};
    tbl[11] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 8'h11};
    tbl[12] = '{4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11};

    do_reset();
    req_data = 32'h13121110;
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      tx_ready  = tbl[i].tr;
      #1;
      chk($sformatf("tbl%0d_txv", i), tx_valid, tbl[i].etv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].eg);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].erdy);
      if (tbl[i].etv) chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].edata);
      cycle();
    end

    // --- Two-byte packet on requester 0 -------------------------------------
    idle_inputs();
    do_reset();
    req_valid = 4'b0001;
    req_data[7:0] = 8'h41;
    #1 chk("s1_idle_txv", tx_valid, 0);
    cycle();
    #1;
    chk("s1_b0_txv", tx_valid, 1);
    chk("s1_b0_data", tx_data, 8'h41);
    cycle();
    req_data[7:0] = 8'h42;
    req_last = 4'b0001;
    #1;
    chk("s1_b1_data", tx_data, 8'h42);
    chk("s1_b1_ready", req_ready, 4'b0001);
    cycle();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("s1_busy_fall", busy, 0);
    chk("s1_grant", grant_id, 0);
    cycle();

    // --- 20-byte packet on 2 split by MAX_BURST, requester 3 waiting --------
    idle_inputs();
    do_reset();
    exp_q.delete();
    for (int b = 0; b < 16; b++) exp_q.push_back(16'(2 * 256 + b));
    exp_q.push_back(16'(3 * 256 + 8'hC3));
    for (int b = 16; b < 20; b++) exp_q.push_back(16'(2 * 256 + b));
    mon_on = 1'b1;
    k2 = 0;
    done3 = 1'b0;
    for (int c = 0; c < 80 && (k2 < 20 || !done3); c++) begin
      req_valid[2]      = (k2 < 20);
      req_data[23:16]   = 8'(k2);
      req_last[2]       = (k2 == 19);
      req_valid[3]      = !done3;
      req_data[31:24]   = 8'hC3;
      req_last[3]       = 1'b1;
      cycle();
      if (acc[2]) k2++;
      if (acc[3]) done3 = 1'b1;
    end
    chk("s3_bytes_sent", k2, 20);
    chk("s3_req3_sent", done3, 1);
    chk("s3_queue_empty", exp_q.size(), 0);
    mon_on = 1'b0;

    // --- tx_ready back-pressure on requester 1 ------------------------------
    idle_inputs();
    cycle();
    do_reset();
    exp_q.delete();
    for (int b = 0; b < 3; b++) exp_q.push_back(16'(1 * 256 + 8'hA0 + b));
    mon_on = 1'b1;
    pat = '{1, 1, 0, 0, 1, 1};
    k = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid[1]    = (k < 3);
      req_data[15:8]  = 8'(8'hA0 + k);
      req_last[1]     = (k == 2);
      tx_ready        = pat[i][0];
      if (i > 0) begin
        #1 chk($sformatf("s4_ready_mirror%0d", i), req_ready, {2'b00, tx_ready, 1'b0});
      end
      cycle();
      if (acc[1]) k++;
    end
    chk("s4_queue_empty", exp_q.size(), 0);
    mon_on = 1'b0;

    // --- Reset mid-packet on requester 3 ------------------------------------
    idle_inputs();
    cycle();
    do_reset();
    req_valid = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      req_data[31:24] = 8'(8'h30 + i);
      cycle();
    end
    req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    chk("s5_rst_cycle_txv", tx_valid, 0);
    chk("s5_rst_cycle_ready", req_ready, 0);
    cycle();
    rst = 1'b0;
    #1;
    chk("s5_after_txv", tx_valid, 0);
    chk("s5_after_busy", busy, 0);
    chk("s5_after_grant", grant_id, 0);
    cycle();
    #1;
    chk("s5_prio_grant", grant_id, 0);
    chk("s5_prio_txv", tx_valid, 1);
    cycle();

    // --- Stalled holder with requester 1 waiting ----------------------------
    idle_inputs();
    cycle();
    do_reset();
    req_valid = 4'b0001;
    req_data[7:0] = 8'h55;
    cycle();
    cycle();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    req_data[15:8] = 8'h66;
    for (int i = 0; i < IT; i++) cycle();
`ifdef UART_ARB_TIMEOUT_EN
    #1;
    chk("s6_terr", timeout_err, 1);
    chk("s6_busy", busy, 0);
    cycle();
    #1;
    chk("s6_grant", grant_id, 1);
    chk("s6_txv", tx_valid, 1);
    chk("s6_data", tx_data, 8'h66);
    cycle();
`else
    #1;
    chk("s6_terr", timeout_err, 0);
    chk("s6_busy", busy, 1);
    chk("s6_grant", grant_id, 0);
    cycle();
    #1;
    chk("s6_blocked_txv", tx_valid, 0);
    chk("s6_blocked_grant", grant_id, 0);
    cycle();
`endif

    // --- Randomized run against the model -----------------------------------
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = ($urandom_range(0, 99) < 85);
        req_last[i]        = ($urandom_range(0, 9) == 0);
        req_data[i*8 +: 8] = 8'($urandom_range(0, 255));
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the run is a few thousand cycles; anything far beyond is a hang.
  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
